ahb_lsu_master: RTL and testbench

AHB_LSU_MASTER -- requirements
Module: ahb_lsu_master

---
 rtl/ahb_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/ahb_lsu_master.sv | 157 +++++++++++++++
 tb/tb_ahb_lsu_master.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and LSU master FSM state type shared across the LSU slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Core-side request size codes
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_ADDR = 2'd1;
  localparam lsu_state_t ST_DATA = 2'd2;
  localparam lsu_state_t ST_RESP = 2'd3;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: store data replicated across lanes,
// load data extracted from its lane and sign/zero extended.
module lsu_lane_align
  import ahb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Lane replication for stores and lane select + extension for loads
  always_comb begin
    rd_byte     = rdata[{addr_lo, 3'b000} +: 8];
    rd_half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wdata_lanes = wdata;
    rdata_ext   = rdata;
    case (size)
      SIZE_BYTE: begin
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{~is_unsigned & rd_byte[7]}}, rd_byte};
      end
      SIZE_HALF: begin
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{~is_unsigned & rd_half[15]}}, rd_half};
      end
      default: begin
        wdata_lanes = wdata;
        rdata_ext   = rdata;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lsu_master.sv
// Single-outstanding load/store unit bridging a core request port to an
// AHB-Lite master. Optional build macro: LSU_MISALIGN_CHECK_EN rejects
// misaligned half/word requests locally instead of issuing them.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// ADDR  | NONSEQ address phase, held until HREADY
// DATA  | data phase, HWDATA driven, HRDATA/HRESP captured on HREADY
// RESP  | one-cycle rsp_valid pulse back to the core
module ahb_lsu_master
  import ahb_pkg::*;
#(
  parameter int unsigned HREADY_TIMEOUT = 255
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
);

  localparam int CW = (HREADY_TIMEOUT > 1) ? $clog2(HREADY_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LOAD = CW'(HREADY_TIMEOUT);

  lsu_state_t  st;
  logic [31:0] a_addr;
  logic        a_we;
  logic [1:0]  a_size;
  logic        a_uns;
  logic [31:0] a_wdata;
  logic [CW-1:0] wait_cnt;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_ext;
  logic        reject;
  logic        timeout_hit;
  logic        unused_resp_hi;

  // Only the error bit of HRESP is meaningful on AHB-Lite
  assign unused_resp_hi = HRESP[1];

  // Requests that complete locally without touching the bus
  always_comb begin
    reject = (req_size == SIZE_ILLEGAL);
`ifdef LSU_MISALIGN_CHECK_EN
    if ((req_size == SIZE_HALF && req_addr[0]) ||
        (req_size == SIZE_WORD && req_addr[1:0] != 2'b00))
      reject = 1'b1;
`endif
  end

  // Down-counter reaches its terminal count on the last permitted wait cycle
  assign timeout_hit = (HREADY_TIMEOUT != 0) && !HREADY && (wait_cnt == CW'(1));

  lsu_lane_align u_align (
    .size        (a_size),
    .addr_lo     (a_addr[1:0]),
    .is_unsigned (a_uns),
    .wdata       (a_wdata),
    .rdata       (HRDATA),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (rdata_ext)
  );

  assign req_ready = (st == ST_IDLE) && !HRESET;
  assign HTRANS    = (st == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = a_addr;
  assign HWRITE    = a_we;
  assign HSIZE     = {1'b0, a_size};
  assign HBURST    = HBURST_SINGLE;
  assign HWDATA    = (st == ST_DATA) ? wdata_lanes : 32'h0;

  // Access sequencing, wait-state timeout and response capture
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      st        <= ST_IDLE;
      a_addr    <= 32'h0;
      a_we      <= 1'b0;
      a_size    <= 2'b00;
      a_uns     <= 1'b0;
      a_wdata   <= 32'h0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      case (st)
        ST_IDLE: begin
          if (req_valid) begin
            a_addr  <= req_addr;
            a_we    <= req_we;
            a_size  <= req_size;
            a_uns   <= req_unsigned;
            a_wdata <= req_wdata;
            if (reject) begin
              st        <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              st       <= ST_ADDR;
              wait_cnt <= TO_LOAD;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            st       <= ST_DATA;
            wait_cnt <= TO_LOAD;
          end else if (timeout_hit) begin
            st        <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            st        <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= HRESP[0];
            rsp_rdata <= (HRESP[0] || a_we) ? 32'h0 : rdata_ext;
          end else if (timeout_hit) begin
            st        <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        default: begin
          st       <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lsu_master.sv
// Self-checking bench for ahb_lsu_master: scoreboard of expected responses
// popped by a monitor on rsp_valid, plus per-scenario bus-timing checks.
module tb_ahb_lsu_master;

  localparam int TO = 4;

  logic        clk;
  logic        HRESET;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Per-access observations filled by the driver
  int          o_lat;
  int          o_addr_cycles;
  bit          o_nonseq;
  logic [31:0] o_haddr;
  logic [2:0]  o_hsize;
  logic [31:0] o_hwdata;
  logic [1:0]  o_htrans_rsp;
  logic        o_rsp_after;
  logic        o_ready_after;
  logic [1:0]  o_htrans_after;

  ahb_lsu_master #(.HREADY_TIMEOUT(TO)) dut (
    .HCLK         (clk),
    .HRESET       (HRESET),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .HADDR        (HADDR),
    .HTRANS       (HTRANS),
    .HWRITE       (HWRITE),
    .HSIZE        (HSIZE),
    .HBURST       (HBURST),
    .HWDATA       (HWDATA),
    .HRDATA       (HRDATA),
    .HREADY       (HREADY),
    .HRESP        (HRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!HRESET && rsp_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid err=%0b rdata=%h, required no response", rsp_err, rsp_rdata);
      end else begin
        e = sb.pop_front();
        if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin
          n_bad++;
          $display("FAIL rsp_data: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   rsp_err, rsp_rdata, e.err, e.rdata);
        end
      end
    end
  end

  // Reference load extraction
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns, input logic [31:0] bus);
    logic [31:0] sh;
    sh = bus >> (addr[1:0] * 8);
    if (size == 2'b00) return uns ? (sh & 32'hFF) : ((sh & 32'hFF) ^ 32'h80) - 32'h80;
    if (size == 2'b01) begin
      sh = bus >> (addr[1] * 16);
      return uns ? (sh & 32'hFFFF) : ((sh & 32'hFFFF) ^ 32'h8000) - 32'h8000;
    end
    return bus;
  endfunction

  // Drives one request, acts as the slave, records bus observations
  task automatic access(input logic [31:0] addr, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] bus_rdata, input logic bus_err,
                        input int la, input int ld,
                        input logic [31:0] exp_rdata, input logic exp_err);
    bit got;
    bit in_data;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_we = we; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
    sb.push_back('{exp_rdata, exp_err});
    got = 0; in_data = 0; o_lat = 0; o_addr_cycles = 0; o_nonseq = 0;
    o_haddr = 32'h0; o_hsize = 3'h0; o_hwdata = 32'h0; o_htrans_rsp = 2'b11;
    while (!got && o_lat < 40) begin
      @(negedge clk);
      o_lat++;
      req_valid = 1'b0;
      if (rsp_valid) begin
        got = 1;
        o_htrans_rsp = HTRANS;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
      end else if (HTRANS == 2'b10) begin
        o_nonseq = 1; o_addr_cycles++; o_haddr = HADDR; o_hsize = HSIZE;
        if (la > 0) begin HREADY = 1'b0; la--; end
        else begin HREADY = 1'b1; in_data = 1; end
      end else if (in_data) begin
        o_hwdata = HWDATA;
        if (ld > 0) begin HREADY = 1'b0; ld--; end
        else begin HREADY = 1'b1; HRDATA = bus_rdata; HRESP = {1'b0, bus_err}; end
      end
    end
    if (!got) o_lat = -1;
    @(negedge clk);
    o_rsp_after = rsp_valid;
    o_ready_after = req_ready;
    o_htrans_after = HTRANS;
  endtask

  task automatic test_reset;
    HRESET = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'h0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 2'b00;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA, rsp_valid, rsp_err, rsp_rdata, req_ready} !== 108'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, required all zero",
               {HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA, rsp_valid, rsp_err, rsp_rdata, req_ready});
    end
    HRESET = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_word_load;
    access(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0, 32'hDEADBEEF, 1'b0);
    n_cmp++;
    if (o_lat !== 3) begin n_bad++; $display("FAIL word_load_latency: got %0d, required 3", o_lat); end
    n_cmp++;
    if ({o_haddr, o_hsize} !== {32'h10, 3'b010}) begin
      n_bad++; $display("FAIL word_load_addr: got haddr=%h hsize=%b, required 00000010/010", o_haddr, o_hsize);
    end
    n_cmp++;
    if ({o_rsp_after, o_ready_after} !== 2'b01) begin
      n_bad++; $display("FAIL rsp_pulse: got rsp_after=%b ready_after=%b, required 0/1", o_rsp_after, o_ready_after);
    end
  endtask

  task automatic test_byte_load;
    access(32'h13, 1'b0, 2'b00, 1'b0, 32'h0, 32'h80000000, 1'b0, 0, 0, 32'hFFFFFF80, 1'b0);
    n_cmp++;
    if (o_lat !== 3) begin n_bad++; $display("FAIL byte_signed_latency: got %0d, required 3", o_lat); end
    access(32'h13, 1'b0, 2'b00, 1'b1, 32'h0, 32'h80000000, 1'b0, 0, 0, 32'h00000080, 1'b0);
    access(32'h02, 1'b0, 2'b01, 1'b0, 32'h0, 32'h80011234, 1'b0, 0, 0, 32'hFFFF8001, 1'b0);
    n_cmp++;
    if (o_hsize !== 3'b001) begin n_bad++; $display("FAIL half_load_hsize: got %b, required 001", o_hsize); end
  endtask

  task automatic test_store_wait;
    access(32'h22, 1'b1, 2'b01, 1'b0, 32'hA5A51234, 32'hFFFFFFFF, 1'b0, 2, 0, 32'h0, 1'b0);
    n_cmp++;
    if (o_lat !== 5) begin n_bad++; $display("FAIL half_store_latency: got %0d, required 5", o_lat); end
    n_cmp++;
    if (o_addr_cycles !== 3) begin n_bad++; $display("FAIL half_store_addr_hold: got %0d, required 3", o_addr_cycles); end
    n_cmp++;
    if ({o_haddr, o_hsize, o_hwdata} !== {32'h22, 3'b001, 32'h12341234}) begin
      n_bad++; $display("FAIL half_store_bus: got haddr=%h hsize=%b hwdata=%h, required 00000022/001/12341234",
                        o_haddr, o_hsize, o_hwdata);
    end
    access(32'h01, 1'b1, 2'b00, 1'b0, 32'h1234565A, 32'h0, 1'b0, 0, 1, 32'h0, 1'b0);
    n_cmp++;
    if ({o_lat, o_hwdata} !== {32'd4, 32'h5A5A5A5A}) begin
      n_bad++; $display("FAIL byte_store_data_wait: got lat=%0d hwdata=%h, required 4/5a5a5a5a", o_lat, o_hwdata);
    end
  endtask

  task automatic test_error_resp;
    access(32'h30, 1'b0, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b1, 0, 0, 32'h0, 1'b1);
    n_cmp++;
    if (o_lat !== 3) begin n_bad++; $display("FAIL error_latency: got %0d, required 3", o_lat); end
  endtask

  task automatic test_timeout;
    access(32'h44, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 99, 0, 32'h0, 1'b1);
    n_cmp++;
    if ({o_lat, o_addr_cycles} !== {32'd5, 32'd4}) begin
      n_bad++; $display("FAIL addr_timeout: got lat=%0d addr_cycles=%0d, required 5/4", o_lat, o_addr_cycles);
    end
    n_cmp++;
    if ({o_htrans_rsp, o_htrans_after} !== 4'b0000) begin
      n_bad++; $display("FAIL timeout_htrans: got %b/%b, required 00/00", o_htrans_rsp, o_htrans_after);
    end
    access(32'h48, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 0, 99, 32'h0, 1'b1);
    n_cmp++;
    if (o_lat !== 2 + TO) begin n_bad++; $display("FAIL data_timeout: got %0d, required %0d", o_lat, 2 + TO); end
    access(32'h4C, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0BADF00D, 1'b0, 0, 3, 32'h0BADF00D, 1'b0);
    n_cmp++;
    if (o_lat !== 6) begin n_bad++; $display("FAIL below_timeout: got %0d, required 6", o_lat); end
  endtask

  task automatic test_illegal_size;
    access(32'h0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, 32'h0, 1'b1);
    n_cmp++;
    if ({o_lat, o_nonseq} !== {32'd1, 1'b0}) begin
      n_bad++; $display("FAIL illegal_size: got lat=%0d nonseq=%b, required 1/0", o_lat, o_nonseq);
    end
  endtask

  task automatic test_misalign;
`ifdef LSU_MISALIGN_CHECK_EN
    access(32'h02, 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 0, 0, 32'h0, 1'b1);
    n_cmp++;
    if ({o_lat, o_nonseq} !== {32'd1, 1'b0}) begin
      n_bad++; $display("FAIL misalign_reject: got lat=%0d nonseq=%b, required 1/0", o_lat, o_nonseq);
    end
`else
    access(32'h02, 1'b0, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 0, 0, 32'hCAFEF00D, 1'b0);
    n_cmp++;
    if ({o_lat, o_nonseq, o_haddr} !== {32'd3, 1'b1, 32'h02}) begin
      n_bad++; $display("FAIL misalign_issue: got lat=%0d nonseq=%b haddr=%h, required 3/1/00000002",
                        o_lat, o_nonseq, o_haddr);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int rsp_seen;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h40; req_we = 1'b1; req_size = 2'b10;
    req_unsigned = 1'b0; req_wdata = 32'h11223344; HREADY = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (HWDATA !== 32'h11223344) begin
      n_bad++; $display("FAIL mid_reset_data_phase: got hwdata=%h, required 11223344", HWDATA);
    end
    HRESET = 1'b1; HREADY = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA, rsp_valid, rsp_err, rsp_rdata, req_ready} !== 108'h0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h, required all zero",
               {HTRANS, HADDR, HWRITE, HSIZE, HBURST, HWDATA, rsp_valid, rsp_err, rsp_rdata, req_ready});
    end
    HRESET = 1'b0; HREADY = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, HTRANS} !== 3'b100) begin
      n_bad++; $display("FAIL mid_reset_release: got ready=%b htrans=%b, required 1/00", req_ready, HTRANS);
    end
    rsp_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    n_cmp++;
    if (rsp_seen !== 0) begin n_bad++; $display("FAIL mid_reset_no_rsp: got %0d pulses, required 0", rsp_seen); end
    access(32'h50, 1'b0, 2'b10, 1'b0, 32'h0, 32'h600DF00D, 1'b0, 0, 0, 32'h600DF00D, 1'b0);
    n_cmp++;
    if (o_lat !== 3) begin n_bad++; $display("FAIL post_reset_latency: got %0d, required 3", o_lat); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, d;
    logic [1:0]  s;
    logic        u;
    int          bad_lat;
    bad_lat = 0;
    for (int i = 0; i < 12; i++) begin
      s = 2'($urandom_range(0, 2));
      a = $urandom & 32'hFFFF_FFFC;
      if (s == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      if (s == 2'b01) a[1] = 1'($urandom_range(0, 1));
      d = $urandom;
      u = 1'($urandom_range(0, 1));
      access(a, 1'b0, s, u, 32'h0, d, 1'b0, 0, 0, model_load(a, s, u, d), 1'b0);
      if (o_lat != 3) bad_lat++;
    end
    n_cmp++;
    if (bad_lat !== 0) begin n_bad++; $display("FAIL b2b_latency: got %0d off-latency accesses, required 0", bad_lat); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_store_wait();
    test_error_resp();
    test_timeout();
    test_illegal_size();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
